// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: mult/div opcodes, the busy-tracker state encoding and default latencies.
package cpu_defs_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int MD_CNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks mult/div unit occupancy: busy for N cycles after an accepted start, then a one-cycle done pulse.
// Starts arriving while busy are dropped; a start during the done cycle is accepted.
module md_busy_tracker
    import cpu_defs_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       md_start,
    input  logic [1:0] md_op,
    output logic       md_busy,
    output logic       md_done
);

    localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MULT_CYCLES - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_CYCLES - 1);

    md_state_t           state;
    logic [MD_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    md_done <= 1'b0;
                    if (md_start) begin
                        md_busy <= 1'b1;
                        if (md_is_div(md_op)) begin
                            state <= ST_DIV;
                            cnt   <= DIV_LOAD;
                        end else begin
                            state <= ST_MUL;
                            cnt   <= MUL_LOAD;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    // last busy cycle is the one where the counter reads zero
                    if (cnt == '0) begin
                        state   <= ST_IDLE;
                        md_busy <= 1'b0;
                        md_done <= 1'b1;
                    end else begin
                        cnt <= cnt - MD_CNT_W'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cnt     <= '0;
                    md_busy <= 1'b0;
                    md_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard unit: combinational stall/flush from register and mult/div hazards, plus a stall counter.
// Stall and flush_e settle in the same cycle; md_busy/md_done come registered from the tracker.
module hazard_stall_ctrl
    import cpu_defs_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_is_md,
    input  logic [4:0]  e_wa,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  e_tnew,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic [1:0]  e_md_op,
    output logic        stall,
    output logic        flush_e,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);

    logic        stall_rs;
    logic        stall_rt;
    logic        stall_md;
    logic [31:0] stall_cnt_q;

    // a source needed sooner than the producer can deliver it; r0 never carries a dependency
    function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] wa,  input logic [1:0] tnew);
        return (src != 5'd0) && (src == wa) && (tuse < tnew);
    endfunction

    always_comb begin
        stall_rs = src_hazard(d_rs, d_tuse_rs, e_wa, e_tnew) || src_hazard(d_rs, d_tuse_rs, m_wa, m_tnew);
        stall_rt = src_hazard(d_rt, d_tuse_rt, e_wa, e_tnew) || src_hazard(d_rt, d_tuse_rt, m_wa, m_tnew);
        stall_md = d_is_md && (md_busy || e_md_start);
        stall    = stall_rs || stall_rt || stall_md;
        flush_e  = stall;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

    md_busy_tracker #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_tracker (
        .clk      (clk),
        .reset    (reset),
        .md_start (e_md_start),
        .md_op    (e_md_op),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: timeline model of mult/div occupancy and stall counting, checked every cycle,
// plus directed scenarios with literal expectations.
module tb_hazard_stall_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_wa, m_wa;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew, e_md_op;
    logic        d_is_md, e_md_start;
    logic        stall, flush_e, md_busy, md_done;
    logic [31:0] stall_cnt;

    hazard_stall_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_is_md    (d_is_md),
        .e_wa       (e_wa),
        .m_wa       (m_wa),
        .e_tnew     (e_tnew),
        .m_tnew     (m_tnew),
        .e_md_start (e_md_start),
        .e_md_op    (e_md_op),
        .stall      (stall),
        .flush_e    (flush_e),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: absolute edge timeline. busy covers the periods after edges bs..be, done the period after edge dn.
    int          edge_n = 0;
    int          bs = -1, be = -2, dn = -1;
    longint      m_scnt = 0;
    logic [31:0] pre_val = '0;
    bit          pre_tog = 1'b0;
    bit          pre_seen = 1'b0;

    function automatic bit m_busy(input int p);
        return (p >= bs) && (p <= be);
    endfunction

    function automatic bit m_src(input logic [4:0] s, input logic [1:0] tu);
        return (s != 0) && (((s == e_wa) && (tu < e_tnew)) || ((s == m_wa) && (tu < m_tnew)));
    endfunction

    function automatic bit m_stall(input int p);
        return m_src(d_rs, d_tuse_rs) || m_src(d_rt, d_tuse_rt) || (d_is_md && (m_busy(p) || e_md_start));
    endfunction

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bs = -1; be = -2; dn = -1; m_scnt = 0;
        end else begin
            if (pre_tog != pre_seen) begin
                m_scnt   = pre_val;
                pre_seen = pre_tog;
            end
            if (m_stall(edge_n) && m_scnt < 64'hFFFF_FFFF) m_scnt++;
            if (e_md_start && !m_busy(edge_n)) begin
                bs = edge_n + 1;
                be = edge_n + (e_md_op[1] ? DC : MC);
                dn = be + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_stall",   32'(stall),   32'(m_stall(edge_n)));
        chk("cyc_flush_e", 32'(flush_e), 32'(m_stall(edge_n)));
        chk("cyc_md_busy", 32'(md_busy), 32'(m_busy(edge_n)));
        chk("cyc_md_done", 32'(md_done), 32'(edge_n == dn));
        chk("cyc_stall_cnt", stall_cnt, (pre_tog != pre_seen) ? pre_val : m_scnt[31:0]);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        d_rs = 0; d_rt = 0; e_wa = 0; m_wa = 0;
        d_tuse_rs = 3; d_tuse_rt = 3; e_tnew = 0; m_tnew = 0;
        d_is_md = 0; e_md_start = 0; e_md_op = 0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        #1;
        chk("rst_md_busy", 32'(md_busy), 0);
        chk("rst_md_done", 32'(md_done), 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        step(2);
        reset = 1'b1;

        // load-use hazard held for seven edges
        e_wa = 5; e_tnew = 2; d_rs = 5; d_tuse_rs = 0;
        #1;
        chk("loaduse_stall", 32'(stall), 1);
        chk("loaduse_flush", 32'(flush_e), 1);
        step(7);
        chk("cnt_after_7", stall_cnt, 7);
        e_tnew = 0;
        #1;
        chk("loaduse_ready", 32'(stall), 0);
        step(1);
        d_rs = 0; e_wa = 0; e_tnew = 2;
        #1;
        chk("zero_reg", 32'(stall), 0);
        step(1);
        clear_inputs();
        d_rt = 7; m_wa = 7; m_tnew = 1; d_tuse_rt = 0;
        #1;
        chk("m_rt_stall", 32'(stall), 1);
        d_tuse_rt = 1;
        #1;
        chk("m_rt_ok", 32'(stall), 0);
        step(1);
        clear_inputs();

        // mult: busy for 5 periods, then done; divu accepted in the done period
        e_md_start = 1; e_md_op = 2'b00; d_is_md = 1;
        #1;
        chk("md_start_stall", 32'(stall), 1);
        step(1);
        e_md_start = 0;
        #1;
        chk("mul_busy_first", 32'(md_busy), 1);
        chk("mul_md_stall", 32'(stall), 1);
        step(4);
        chk("mul_busy_last", 32'(md_busy), 1);
        step(1);
        chk("mul_done", 32'(md_done), 1);
        chk("mul_done_nobusy", 32'(md_busy), 0);
        chk("mul_done_nostall", 32'(stall), 0);
        e_md_start = 1; e_md_op = 2'b11; d_is_md = 0;
        step(1);
        e_md_start = 0;
        chk("b2b_done_low", 32'(md_done), 0);
        chk("b2b_busy", 32'(md_busy), 1);
        step(9);
        chk("divu_busy_last", 32'(md_busy), 1);
        step(1);
        chk("divu_done", 32'(md_done), 1);
        step(1);

        // div with an ignored restart three edges in
        e_md_start = 1; e_md_op = 2'b10;
        step(1);
        e_md_start = 0;
        step(2);
        e_md_start = 1; e_md_op = 2'b00;
        step(1);
        e_md_start = 0;
        step(6);
        chk("div_busy_10", 32'(md_busy), 1);
        chk("div_nodone_10", 32'(md_done), 0);
        step(1);
        chk("div_done_11", 32'(md_done), 1);
        chk("div_busy_11", 32'(md_busy), 0);
        step(1);
        chk("div_no_restart", 32'(md_busy), 0);
        chk("div_done_once", 32'(md_done), 0);

        // reset in the middle of a divide
        step(1);
        e_md_start = 1; e_md_op = 2'b10;
        step(1);
        e_md_start = 0;
        step(3);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(md_busy), 0);
        chk("rst_mid_cnt", stall_cnt, 0);
        step(2);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("rst_no_done", 32'(md_done), 0);
        end
        chk("rst_cnt_zero", stall_cnt, 0);

        // saturation from a preloaded count
        pre_val = 32'hFFFF_FFFC;
        dut.stall_cnt_q = 32'hFFFF_FFFC;
        pre_tog = ~pre_tog;
        e_wa = 5; e_tnew = 2; d_rs = 5; d_tuse_rs = 0;
        step(2);
        chk("sat_pre", stall_cnt, 32'hFFFF_FFFE);
        step(3);
        chk("sat_hold", stall_cnt, 32'hFFFF_FFFF);
        clear_inputs();
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
